reg_file_wb: RTL and testbench
==============================

# reg_file_wb

- Architectural register file for the single-cycle CPU: 32 × 32-bit registers.
- It is the consuming end of the destination-register select path. It accepts the 5-bit write-back address chosen by the destination mux (rt or rd), plus the write-back data and the RegWrite strobe.
- It serves two combinational operand read ports (rs, rt) and one debug read port.
- It sits between the decode stage (read addresses), the write-back mux (write data) and the datapath ALU inputs.

## Interface

Parameters
- DATA_W, 32, register width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored value only

Ports
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rs_addr  input  ADDR_W  operand A read index
- rt_addr  input  ADDR_W  operand B read index
- rs_data  output  DATA_W  operand A read data
- rt_data  output  DATA_W  operand B read data
- wr_addr  input  ADDR_W  write-back destination index (output of destination mux)
- wr_data  input  DATA_W  write-back data
- RegWrite  input  1  write enable from control unit
- dbg_addr  input  ADDR_W  debug/testbench read index
- dbg_data  output  DATA_W  debug read data

## Operation

- **Storage.** Array regs[0..2**ADDR_W-1] of DATA_W bits. regs[0] is hardwired to zero.
  - It is never written, even when RegWrite=1 and wr_addr=0.
- **Write.** On a rising clk edge with rst=0 and RegWrite=1 and wr_addr≠0: regs[wr_addr] ← wr_data.
  - RegWrite=0 leaves the array unchanged, regardless of wr_addr or wr_data.
- **Reset.** On a rising clk edge with rst=1, every register is cleared to 0.
  - rst has priority over a simultaneous write; that write is dropped.
- **Read (per port p ∈ {rs, rt, dbg}).**
  - addr_p = 0 → 0.
  - Otherwise, if BYPASS=1 and rst=0 and RegWrite=1 and wr_addr = addr_p → wr_data (forwarded).
  - Otherwise → regs[addr_p].
- **Bypass suppression.** Bypass is disabled while rst=1, so all read ports show stored values during reset.
- **Port independence.** All read ports are independent. Identical addresses on several ports return identical data.
- **Width rule.** No sign/zero extension inside the block. Data passes through at DATA_W unchanged.

## Timing

- Read ports are purely combinational from addr, wr_addr, wr_data, RegWrite and rst: zero-cycle latency.
- Write latency is 1 cycle. Data written at edge N is visible without bypass from edge N onward.
- With BYPASS=1 the new value is visible in the same cycle the write is presented.
- Output reset values:
  - After the first rst edge, every read port returns 0 for every address until the next write.
  - Before any reset, contents are undefined (X in simulation), except address 0, which is always 0.
- **Simultaneous events:**
  - Write and read of the same nonzero index in one cycle → forwarded value (BYPASS=1) or old value (BYPASS=0).
  - Write to index 0 with a read of index 0 → 0.
  - Reset asserted mid-program → clears on that edge. The next cycle reads 0 on all ports.
- No handshake. RegWrite is a single-cycle qualifier sampled every edge.
- Back-to-back writes to the same index on consecutive edges → last write wins, one value per edge.

## Structure

Shared package (cpu_pkg):
- DATA_W and ADDR_W defaults
- REG_ZERO = 0
- REG_RA = 31, the link register used by jal write-back; shared with the destination mux select

Sub-module:
- rf_read_port, instantiated three times (rs, rt, dbg).
- It performs the zero-index check, the bypass compare and the select between array value and wr_data.

Top level holds:
- the register array
- the synchronous reset/write always-block

## Test plan

- **Reset:** pulse rst one cycle; sweep dbg_addr 0..31 → dbg_data = 0 for all; rs_data/rt_data = 0.
- **Write/readback:** RegWrite=1, wr_addr=5, wr_data=0xDEADBEEF, one edge; then RegWrite=0, rs_addr=5 → rs_data=0xDEADBEEF; rt_addr=6 → rt_data=0.
- **Zero register:** RegWrite=1, wr_addr=0, wr_data=0xFFFFFFFF, edge; then rs_addr=0 → 0, and dbg over all addresses shows no other register changed.
- **Bypass (BYPASS=1):** regs[7]=0x11111111; present RegWrite=1, wr_addr=7, wr_data=0x22222222, rs_addr=rt_addr=7 → both read 0x22222222 before the edge. Repeat with BYPASS=0 → 0x11111111 before the edge, 0x22222222 after.
- **Reset vs write:** rst=1 and RegWrite=1, wr_addr=31, wr_data=0x12345678 on the same edge → regs[31]=0. During that cycle, rt_addr=31 reads the stored value, not 0x12345678.
- **Destination mux integration:** drive wr_addr alternately with rt=9 and rd=10 over two write cycles with data 0xA and 0xB → regs[9]=0xA, regs[10]=0xB, all others unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and the architectural register
// indices that both the register file and the destination mux agree on.
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;
  // jal link register; the destination mux forces wr_addr to this index
  localparam int REG_RA   = 31;
endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: r0 forced to zero, then optional
// same-cycle forwarding of the pending write, else the stored array value.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W_P-1:0] addr,
  input  logic [DATA_W_P-1:0] stored,
  input  logic [ADDR_W_P-1:0] wr_addr,
  input  logic [DATA_W_P-1:0] wr_data,
  input  logic                fwd_en,
  output logic [DATA_W_P-1:0] data
);
  always_comb begin
    data = stored;
    if (addr == ADDR_W_P'(REG_ZERO))
      data = '0;
    else if ((BYPASS != 0) && fwd_en && (wr_addr == addr))
      data = wr_data;
  end
endmodule

// File: rtl/reg_file_wb.sv
// 32x32 architectural register file: one write-back port, rs/rt operand
// read ports and a debug read port, all reads combinational.
module reg_file_wb
  import cpu_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W_P-1:0] rs_addr,
  input  logic [ADDR_W_P-1:0] rt_addr,
  output logic [DATA_W_P-1:0] rs_data,
  output logic [DATA_W_P-1:0] rt_data,
  input  logic [ADDR_W_P-1:0] wr_addr,
  input  logic [DATA_W_P-1:0] wr_data,
  input  logic                RegWrite,
  input  logic [ADDR_W_P-1:0] dbg_addr,
  output logic [DATA_W_P-1:0] dbg_data
);
  localparam int DEPTH     = 2**ADDR_W_P;
  localparam int NUM_PORTS = 3;

  logic [DATA_W_P-1:0] regs [DEPTH];

  logic [NUM_PORTS-1:0][ADDR_W_P-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_W_P-1:0] rd_data;
  logic                               fwd_en;

  // Reset wins over a coincident write, and also blocks forwarding so the
  // read ports show stored contents for the whole reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (RegWrite && (wr_addr != ADDR_W_P'(REG_ZERO))) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign fwd_en  = RegWrite && !rst;
  assign rd_addr = {dbg_addr, rt_addr, rs_addr};
  assign {dbg_data, rt_data, rs_data} = rd_data;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    rf_read_port #(
      .DATA_W_P(DATA_W_P),
      .ADDR_W_P(ADDR_W_P),
      .BYPASS  (BYPASS)
    ) u_port (
      .addr   (rd_addr[p]),
      .stored (regs[rd_addr[p]]),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .fwd_en (fwd_en),
      .data   (rd_data[p])
    );
  end
endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: a forwarding and a non-forwarding instance
// share stimulus; an array model predicts every read port each cycle.
module tb_reg_file_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
  logic [31:0] wr_data;
  logic        RegWrite;
  logic [31:0] rs_b, rt_b, dbg_b;
  logic [31:0] rs_n, rt_n, dbg_n;

  always #5 clk = ~clk;

  reg_file_wb #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_b), .rt_data(rt_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .RegWrite(RegWrite), .dbg_addr(dbg_addr), .dbg_data(dbg_b));

  reg_file_wb #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_n), .rt_data(rt_n), .wr_addr(wr_addr), .wr_data(wr_data),
    .RegWrite(RegWrite), .dbg_addr(dbg_addr), .dbg_data(dbg_n));

  typedef struct {
    string       name;
    logic [31:0] rs_b, rt_b, dbg_b, rs_n, rt_n, dbg_n;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [32];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && !rst && RegWrite && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  task automatic cmp(input string name, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", name, fld, act, req);
    end
  endtask

  // Monitor: reads settle by mid-cycle; one expectation per cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp(e.name, "rs_byp",  rs_b,  e.rs_b);
      cmp(e.name, "rt_byp",  rt_b,  e.rt_b);
      cmp(e.name, "dbg_byp", dbg_b, e.dbg_b);
      cmp(e.name, "rs_nob",  rs_n,  e.rs_n);
      cmp(e.name, "rt_nob",  rt_n,  e.rt_n);
      cmp(e.name, "dbg_nob", dbg_n, e.dbg_n);
    end
  end

  // Drive one cycle (called just after a rising edge), queue predictions,
  // then advance the model across the next edge.
  task automatic step(input string name, input bit r, input bit we,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb,
                      input logic [4:0] rd);
    exp_t e;
    rst = r; RegWrite = we; wr_addr = wa; wr_data = wd;
    rs_addr = ra; rt_addr = rb; dbg_addr = rd;
    e.name  = name;
    e.rs_b  = model_read(ra, 1'b1);
    e.rt_b  = model_read(rb, 1'b1);
    e.dbg_b = model_read(rd, 1'b1);
    e.rs_n  = model_read(ra, 1'b0);
    e.rt_n  = model_read(rb, 1'b0);
    e.dbg_n = model_read(rd, 1'b0);
    sb_q.push_back(e);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (we && wa != 0) begin
      mem[wa] = wd;
    end
    #1;
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 32; i++) step(name, 0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
  endtask

  initial begin
    rst = 1'b1; RegWrite = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0; dbg_addr = '0;
    @(posedge clk); #1;

    // Reset, then every port reads zero everywhere
    step("reset", 1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    sweep("post_reset");

    // Write/readback
    step("wr5", 0, 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
    step("rd5", 0, 0, 5'd5, 32'h0, 5'd5, 5'd6, 5'd5);

    // Zero register is never written, bypass of r0 still reads 0
    step("wr0", 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    sweep("zero_reg");

    // Forwarding vs stored value on a same-index write
    step("seed7", 0, 1, 5'd7, 32'h11111111, 5'd0, 5'd0, 5'd0);
    step("byp7",  0, 1, 5'd7, 32'h22222222, 5'd7, 5'd7, 5'd7);
    step("aft7",  0, 0, 5'd7, 32'h0, 5'd7, 5'd7, 5'd7);

    // Reset beats a coincident write; reads show stored data meanwhile
    step("seed31", 0, 1, 5'd31, 32'hCAFEF00D, 5'd0, 5'd0, 5'd0);
    step("rst_wr", 1, 1, 5'd31, 32'h12345678, 5'd31, 5'd31, 5'd31);
    step("aft_rst", 0, 0, 5'd0, 32'h0, 5'd31, 5'd31, 5'd31);

    // Destination mux alternating rt/rd select, plus link register
    for (int k = 0; k < 2; k++) begin
      logic [4:0] dst;
      dst = (k == 0) ? 5'd9 : 5'd10;
      step("dst_mux", 0, 1, dst, 32'hA + k, dst, 5'd9, 5'd10);
    end
    step("ra_link", 0, 1, 5'd31, 32'h00400008, 5'd31, 5'd9, 5'd10);
    sweep("dst_mux_sweep");

    // Back-to-back writes to one index: last write wins
    step("b2b_a", 0, 1, 5'd12, 32'h1, 5'd12, 5'd12, 5'd12);
    step("b2b_b", 0, 1, 5'd12, 32'h2, 5'd12, 5'd12, 5'd12);
    step("b2b_c", 0, 0, 5'd12, 32'h3, 5'd12, 5'd12, 5'd12);

    // Randomized traffic with frequent address collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  wa, ra, rb, rd;
      logic [31:0] wd;
      bit          r, we;
      r  = ($urandom_range(39) == 0);
      we = $urandom_range(1);
      wa = 5'($urandom_range(31));
      wd = $urandom;
      ra = ($urandom_range(2) == 0) ? wa : 5'($urandom_range(31));
      rb = ($urandom_range(2) == 0) ? wa : 5'($urandom_range(31));
      rd = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
      step("rand", r, we, wa, wd, ra, rb, rd);
    end
    sweep("final_sweep");

    @(posedge clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
